cpu_enable_gen: RTL and testbench
=================================

Name: cpu_enable_gen

Overview:
- Upstream stage of the CPU core. Generates the single-cycle `enable` strobe that advances the instruction pointer and register file.
- Supports free-running at a slow or turbo rate, pause/resume, and single-step from raw board push-buttons.
- Sits between the board switches/buttons and the CPU `enable` input, in the same clock domain as the CPU.

Parameters:
- SLOW_DIV, 50_000_000, clk cycles between enable pulses when turbo=0 (must be >= 2)
- FAST_DIV, 500_000, clk cycles between enable pulses when turbo=1 (must be >= 2)
- DEBOUNCE_CYCLES, 500_000, consecutive stable-high cycles before a button press is accepted (must be >= 1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- turbo  input  1  rate select: 0 = SLOW_DIV, 1 = FAST_DIV (level; asynchronous switch)
- run_btn  input  1  raw run/pause push-button, active-high, asynchronous
- step_btn  input  1  raw single-step push-button, active-high, asynchronous
- instruction_pointer  input  8  current CPU instruction pointer (used by optional feature only)
- bp_addr  input  8  breakpoint address (used by optional feature only)
- enable  output  1  single-cycle CPU advance strobe
- running  output  1  1 = RUNNING state, 0 = PAUSED
- step_count  output  16  enable pulses issued since reset (wraps)

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high. All state updates on posedge clk; reset has priority over all other events.
- Reset values: enable=0, running=1 (state RUNNING), step_count=0, divider counter=0, synchronizers=0, debounce counters=0, debounced levels=0.
- Input conditioning: turbo, run_btn and step_btn each pass through a 2-flop synchronizer.
- Debounce, per button:
  - Counter increments while the synced input is 1; clears to 0 when it is 0.
  - Debounced level goes 1 when the counter reaches DEBOUNCE_CYCLES; goes 0 when the synced input is 0.
  - Press event = one-cycle pulse on the debounced level 0->1 transition.
  - Holding a button produces exactly one event.
- FSM states: RUNNING, PAUSED.
  - RUNNING: run press -> PAUSED. Step press ignored.
  - PAUSED: run press -> RUNNING. Step press -> one enable pulse, stay PAUSED.
  - Run and step press in the same cycle: run wins, step is discarded.
- Divider:
  - Counter counts 0..DIV-1, DIV = FAST_DIV if synced turbo=1, else SLOW_DIV.
  - In RUNNING, when counter==DIV-1: counter->0 and enable=1 next cycle. Enable period is exactly DIV cycles.
  - Counter clears to 0 on any change of synced turbo, on entry to RUNNING, and while PAUSED. First pulse after resume therefore comes DIV cycles later.
- Step latency: step press event in cycle N -> enable=1 in cycle N+1 only.
- enable is registered and never high for two consecutive cycles.
- Pause press in the same cycle the divider wraps: pause wins, no enable issued.
- step_count increments by 1 in every cycle enable=1 and wraps 0xFFFF->0x0000.
- Reset mid-debounce or mid-count discards all partial progress; no enable is emitted in the cycle after reset.

Optional Feature:
- Macro: CPU_ENABLE_GEN_BREAKPOINT_EN.
- Defined: when running=1 and a divider wrap would issue enable while instruction_pointer==bp_addr, no enable is issued and the FSM goes to PAUSED. Resume with run press; the first enable after resume is not blocked even if the IP still equals bp_addr. Step presses are never blocked.
- Undefined: instruction_pointer and bp_addr are ignored (ports remain, unused); behaviour as above.

Test Plan:
- Bench parameters: SLOW_DIV=10, FAST_DIV=3, DEBOUNCE_CYCLES=4.
- Reset then turbo=0 held -> enable pulses exactly every 10 cycles; running=1; step_count=3 after 3 pulses.
- turbo 0->1 mid-count -> counter restarts; first pulse 3 cycles after the synced turbo change, then every 3 cycles.
- run_btn high 2 cycles (bounce) then low -> no state change. run_btn held 20 cycles -> exactly one toggle to PAUSED; no enable while paused for 50 cycles.
- PAUSED, step_btn held high -> exactly one enable, 1 cycle after the press event; step_count +1. Release and press again -> one more.
- run and step press events in the same cycle while PAUSED -> RUNNING, no extra enable; first enable 10 cycles after entry.
- Breakpoint (macro defined): bp_addr=0x05, IP=0x05 when the divider wraps -> no enable, running=0. Run press -> next enable 10 cycles later despite IP=0x05.

Source files
------------

// File: rtl/cpu_enable_gen.sv
// CPU advance-strobe generator: free-running slow/turbo rate, pause/resume and single-step from raw buttons.
// Optional breakpoint stop enabled by defining CPU_ENABLE_GEN_BREAKPOINT_EN.
module cpu_enable_gen #(
  parameter int SLOW_DIV        = 50_000_000,
  parameter int FAST_DIV        = 500_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        turbo,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic [7:0]  instruction_pointer,
  input  logic [7:0]  bp_addr,
  output logic        enable,
  output logic        running,
  output logic [15:0] step_count
);

  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
  localparam logic [DB_W-1:0]  DB_DONE   = DB_W'(DEBOUNCE_CYCLES);

  localparam logic [0:0] ST_PAUSED  = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  // Two-flop synchronizers, bit order {step, run, turbo}.
  logic [2:0] sync_s1;
  logic [2:0] sync_s2;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= {step_btn, run_btn, turbo};
      sync_s2 <= sync_s1;
    end
  end

  // Per-button debounce; press[0] = run, press[1] = step.
  logic [1:0] press;

  for (genvar g = 0; g < 2; g++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            level;
    logic            level_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt     <= '0;
        level   <= 1'b0;
        level_q <= 1'b0;
      end else begin
        level_q <= level;
        if (!sync_s2[g+1]) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (cnt != DB_DONE) begin
          cnt <= cnt + 1'b1;
        end else begin
          level <= 1'b1;
        end
      end
    end

    assign press[g] = level & ~level_q;
  end

  logic run_press;
  logic step_press;
  assign run_press  = press[0];
  assign step_press = press[1];

  logic [0:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             turbo_q;
  logic             turbo_changed;
  logic             wrap;
  logic             bp_hit;

  // turbo_q is the rate select actually in force; a new synced value restarts the period.
  assign turbo_changed = sync_s2[0] != turbo_q;
  assign wrap          = (state == ST_RUNNING) &&
                         (div_cnt == (turbo_q ? FAST_LAST : SLOW_LAST));

`ifdef CPU_ENABLE_GEN_BREAKPOINT_EN
  // Set on resume so the first wrap afterwards is never blocked by the breakpoint.
  logic bp_skip;

  assign bp_hit = wrap && !bp_skip && (instruction_pointer == bp_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_skip <= 1'b0;
    end else if (state == ST_PAUSED && run_press) begin
      bp_skip <= 1'b1;
    end else if (wrap) begin
      bp_skip <= 1'b0;
    end
  end
`else
  logic unused_bp_inputs;

  assign bp_hit           = 1'b0;
  assign unused_bp_inputs = ^{instruction_pointer, bp_addr};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUNNING;
      div_cnt    <= '0;
      turbo_q    <= 1'b0;
      enable     <= 1'b0;
      step_count <= '0;
    end else begin
      turbo_q    <= sync_s2[0];
      step_count <= step_count + {15'd0, enable};
      enable     <= 1'b0;
      if (state == ST_RUNNING) begin
        // A pause request beats a wrap in the same cycle.
        if (run_press || bp_hit) begin
          state   <= ST_PAUSED;
          div_cnt <= '0;
        end else if (wrap) begin
          enable  <= 1'b1;
          div_cnt <= '0;
        end else if (turbo_changed) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt <= '0;
        if (run_press) begin
          state <= ST_RUNNING;
        end else if (step_press) begin
          enable <= 1'b1;
        end
      end
    end
  end

  assign running = (state == ST_RUNNING);

endmodule

// File: tb/tb_cpu_enable_gen.sv
// Bench for cpu_enable_gen: event-schedule model checked every cycle plus hand-computed pinned values.
// Breakpoint scenarios follow CPU_ENABLE_GEN_BREAKPOINT_EN.
module tb_cpu_enable_gen;

  localparam int SLOW = 10;
  localparam int FAST = 3;
  localparam int DB   = 4;
`ifdef CPU_ENABLE_GEN_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        turbo;
  logic        run_btn;
  logic        step_btn;
  logic [7:0]  instruction_pointer;
  logic [7:0]  bp_addr;
  logic        enable;
  logic        running;
  logic [15:0] step_count;

  cpu_enable_gen #(
    .SLOW_DIV       (SLOW),
    .FAST_DIV       (FAST),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .turbo              (turbo),
    .run_btn            (run_btn),
    .step_btn           (step_btn),
    .instruction_pointer(instruction_pointer),
    .bp_addr            (bp_addr),
    .enable             (enable),
    .running            (running),
    .step_count         (step_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int now_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Model: a button press takes effect 3 cycles after the 5th consecutive high sample;
  // a rate change takes effect 3 samples late; pulses are scheduled at absolute cycle numbers.
  bit          m_valid = 1'b0;
  bit          m_run;
  bit          m_en;
  bit          m_skip;
  logic [15:0] m_cnt;
  int          m_cyc;
  int          m_due;
  int          run_streak;
  int          step_streak;
  bit [2:0]    run_pipe;
  bit [2:0]    step_pipe;
  bit [2:0]    t_hist;
  bit          run_act;
  bit          step_act;
  int          p_next;

  always @(posedge clk) begin
    if (reset) begin
      m_valid     = 1'b1;
      m_run       = 1'b1;
      m_en        = 1'b0;
      m_skip      = 1'b0;
      m_cnt       = '0;
      m_cyc       = 0;
      m_due       = SLOW;
      run_streak  = 0;
      step_streak = 0;
      run_pipe    = '0;
      step_pipe   = '0;
      t_hist      = '0;
    end else begin
      m_cyc++;
      m_cnt    = m_cnt + 16'(m_en);
      run_act  = run_pipe[2];
      step_act = step_pipe[2];
      p_next   = t_hist[1] ? FAST : SLOW;
      m_en     = 1'b0;
      if (m_run) begin
        if (run_act) begin
          m_run = 1'b0;
        end else if (m_cyc == m_due) begin
          if (BP && instruction_pointer == bp_addr && !m_skip) begin
            m_run = 1'b0;
          end else begin
            m_en   = 1'b1;
            m_skip = 1'b0;
          end
          m_due = m_cyc + p_next;
        end else if (t_hist[1] != t_hist[2]) begin
          m_due = m_cyc + p_next;
        end
      end else if (run_act) begin
        m_run  = 1'b1;
        m_skip = 1'b1;
        m_due  = m_cyc + p_next;
      end else if (step_act) begin
        m_en = 1'b1;
      end
      run_streak  = run_btn  ? run_streak + 1  : 0;
      step_streak = step_btn ? step_streak + 1 : 0;
      run_pipe    = {run_pipe[1:0],  run_streak  == DB + 1};
      step_pipe   = {step_pipe[1:0], step_streak == DB + 1};
      t_hist      = {t_hist[1:0], turbo};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_enable",     32'(enable),     32'(m_en));
      check("model_running",    32'(running),    32'(m_run));
      check("model_step_count", 32'(step_count), 32'(m_cnt));
    end
  end

  task automatic go(input int n);
    while (now_n < n) begin
      @(negedge clk);
      now_n++;
    end
  endtask

  task automatic count_en(input int n, output int c);
    c = 0;
    while (now_n < n) begin
      @(negedge clk);
      now_n++;
      if (enable) c++;
    end
  endtask

  int c1;
  int c2;

  initial begin
    reset               = 1'b1;
    turbo               = 1'b0;
    run_btn             = 1'b0;
    step_btn            = 1'b0;
    instruction_pointer = 8'h00;
    bp_addr             = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    now_n = 0;
    check("rst_enable",     32'(enable),     32'd0);
    check("rst_running",    32'(running),    32'd1);
    check("rst_step_count", 32'(step_count), 32'd0);

    go(9);   check("slow_first_early", 32'(enable), 32'd0);
    go(10);  check("slow_first",       32'(enable), 32'd1);
    go(31);  check("slow_count3",      32'(step_count), 32'd3);
             check("slow_running",     32'(running), 32'd1);

    go(33);  turbo = 1'b1;
    go(39);  check("fast_first",    32'(enable), 32'd1);
    go(40);  check("fast_not_slow", 32'(enable), 32'd0);
    go(42);  check("fast_second",   32'(enable), 32'd1);
    go(50);  turbo = 1'b0;
    go(63);  check("slow_after_turbo", 32'(enable), 32'd1);

    go(65);  run_btn = 1'b1;
    go(67);  run_btn = 1'b0;
    go(80);  check("bounce_ignored", 32'(running), 32'd1);

    go(85);  run_btn = 1'b1;
    go(93);  check("pause_beats_wrap", 32'(enable),  32'd0);
             check("paused",           32'(running), 32'd0);
    count_en(105, c1);
    run_btn = 1'b0;
    count_en(143, c2);
    check("paused_no_enable", 32'(c1 + c2), 32'd0);

    go(145); check("count_before_step", 32'(step_count), 32'd11);
             step_btn = 1'b1;
    go(152); check("step_early", 32'(enable), 32'd0);
    go(153); check("step_pulse", 32'(enable), 32'd1);
    count_en(165, c1);
    check("step_held_once", 32'(c1), 32'd0);
    check("step_count_12",  32'(step_count), 32'd12);
    step_btn = 1'b0;
    go(170); step_btn = 1'b1;
    go(178); check("step2_pulse", 32'(enable), 32'd1);
    count_en(185, c1);
    check("step2_held_once", 32'(c1), 32'd0);
    step_btn = 1'b0;
    go(190); check("step_count_13", 32'(step_count), 32'd13);

    go(195); run_btn = 1'b1; step_btn = 1'b1;
    go(203); check("both_resume_running", 32'(running), 32'd1);
             check("both_no_step_enable", 32'(enable),  32'd0);
    count_en(212, c1);
    check("resume_quiet", 32'(c1), 32'd0);
    go(213); check("resume_first_pulse", 32'(enable), 32'd1);
    go(215); run_btn = 1'b0; step_btn = 1'b0;

    go(220); step_btn = 1'b1;
    go(235); step_btn = 1'b0;
    go(236); check("step_ignored_running", 32'(step_count), 32'd16);
             check("still_running",        32'(running),    32'd1);

    go(240); run_btn = 1'b1;
    go(243); reset = 1'b1;
    go(244); reset = 1'b0;
             check("rst2_enable",     32'(enable),     32'd0);
             check("rst2_running",    32'(running),    32'd1);
             check("rst2_step_count", 32'(step_count), 32'd0);
    go(251); check("rst2_debounce_restarted", 32'(running), 32'd1);
    go(252); check("rst2_pause",              32'(running), 32'd0);
    go(255); run_btn = 1'b0;
    go(260); run_btn = 1'b1;
    go(268); check("resume2_running", 32'(running), 32'd1);
    go(275); run_btn = 1'b0;
    go(278); check("resume2_pulse", 32'(enable), 32'd1);
    go(280); instruction_pointer = 8'h05; bp_addr = 8'h05;
`ifdef CPU_ENABLE_GEN_BREAKPOINT_EN
    go(288); check("bp_hit_no_enable", 32'(enable),  32'd0);
             check("bp_hit_paused",    32'(running), 32'd0);
    go(290); run_btn = 1'b1;
    go(298); check("bp_resume_running", 32'(running), 32'd1);
    go(300); run_btn = 1'b0;
    go(308); check("bp_first_not_blocked", 32'(enable), 32'd1);
    go(318); check("bp_hit_again_no_enable", 32'(enable),  32'd0);
             check("bp_hit_again_paused",    32'(running), 32'd0);
`else
    go(288); check("bp_ignored_enable",  32'(enable),  32'd1);
             check("bp_ignored_running", 32'(running), 32'd1);
`endif
    go(330);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
